// File: rtl/rf_mp_sb_if.sv
// rf_mp_sb_if: ID/WB-side bus of the register file (read, write, scoreboard, bulk-clear signals)
interface rf_mp_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic [AW-1:0] i_rd_addr1;
    logic [AW-1:0] i_rd_addr2;
    logic          i_sb_set;
    logic [AW-1:0] i_sb_addr;
    logic          i_clr_req;
    logic [DW-1:0] o_rd_data1;
    logic [DW-1:0] o_rd_data2;
    logic          o_sb_pend1;
    logic          o_sb_pend2;
    logic          o_clr_busy;
    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr1, i_rd_addr2, i_sb_set, i_sb_addr, i_clr_req,
        input  o_rd_data1, o_rd_data2, o_sb_pend1, o_sb_pend2, o_clr_busy
    );
    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr1, i_rd_addr2, i_sb_set, i_sb_addr, i_clr_req,
        output o_rd_data1, o_rd_data2, o_sb_pend1, o_sb_pend2, o_clr_busy
    );
endinterface

// File: rtl/rf_mp_sb.sv
// rf_mp_sb: 2R/1W register file with write bypass, optional zero entry,
// per-entry pending-write scoreboard and a one-entry-per-cycle bulk-clear sweep
module rf_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        rst,
    rf_mp_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t           r_state;
    logic             r_busy;
    logic [AW-1:0]    r_ptr;
    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic             w_wr, w_set, w_z1, w_z2, w_b1, w_b2;
    assign w_wr  = r_state == IDLE && bus.i_wr_en && !(ZERO_REG != 0 && bus.i_wr_addr == '0);
    assign w_set = r_state == IDLE && bus.i_sb_set && !(ZERO_REG != 0 && bus.i_sb_addr == '0);
    assign w_z1  = ZERO_REG != 0 && bus.i_rd_addr1 == '0;
    assign w_z2  = ZERO_REG != 0 && bus.i_rd_addr2 == '0;
    assign w_b1  = BYPASS != 0 && r_state == IDLE && bus.i_wr_en && bus.i_wr_addr == bus.i_rd_addr1;
    assign w_b2  = BYPASS != 0 && r_state == IDLE && bus.i_wr_en && bus.i_wr_addr == bus.i_rd_addr2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_pend  <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
        end else if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
            r_ptr        <= (r_ptr == LAST) ? r_ptr : r_ptr + AW'(1);
            if (r_ptr == LAST) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            if (w_wr) begin
                r_mem[bus.i_wr_addr]  <= bus.i_wr_data;
                r_pend[bus.i_wr_addr] <= 1'b0;
            end
            // a newer producer issued on the same edge keeps the entry pending
            if (w_set) r_pend[bus.i_sb_addr] <= 1'b1;
            if (bus.i_clr_req) begin
                r_state <= CLEAR;
                r_busy  <= 1'b1;
                r_ptr   <= FIRST;
                r_pend  <= '0;
            end
        end
    end
    always_comb begin
        bus.o_rd_data1 = w_z1 ? '0 : w_b1 ? bus.i_wr_data : r_mem[bus.i_rd_addr1];
        bus.o_rd_data2 = w_z2 ? '0 : w_b2 ? bus.i_wr_data : r_mem[bus.i_rd_addr2];
        bus.o_sb_pend1 = (w_z1 || w_b1) ? 1'b0 : r_pend[bus.i_rd_addr1];
        bus.o_sb_pend2 = (w_z2 || w_b2) ? 1'b0 : r_pend[bus.i_rd_addr2];
        bus.o_clr_busy = r_busy;
    end
endmodule

// File: tb/tb_rf_mp_sb.sv
// tb_rf_mp_sb: scoreboard bench driving a default instance and a ZERO_REG=0/BYPASS=0 instance
module tb_rf_mp_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        wr_en = 0, sb_set = 0, clr_req = 0;
    logic [4:0]  wr_addr = 0, rd_addr1 = 0, rd_addr2 = 0, sb_addr = 0;
    logic [31:0] wr_data = 0;
    int n_tot = 0, n_bad = 0;
    typedef struct { string tag; logic [31:0] v; } ent_t;
    ent_t q[$];
    logic [31:0] m_mem  [2][32];
    logic        m_pend [2][32];
    logic        m_clr  [2];
    logic [4:0]  m_ptr  [2];
    always #5 clk = ~clk;
    rf_mp_sb_if #(.DW(32), .AW(5)) b1 ();
    rf_mp_sb_if #(.DW(32), .AW(5)) b0 ();
    assign b1.i_wr_en = wr_en;      assign b0.i_wr_en = wr_en;
    assign b1.i_wr_addr = wr_addr;  assign b0.i_wr_addr = wr_addr;
    assign b1.i_wr_data = wr_data;  assign b0.i_wr_data = wr_data;
    assign b1.i_rd_addr1 = rd_addr1; assign b0.i_rd_addr1 = rd_addr1;
    assign b1.i_rd_addr2 = rd_addr2; assign b0.i_rd_addr2 = rd_addr2;
    assign b1.i_sb_set = sb_set;    assign b0.i_sb_set = sb_set;
    assign b1.i_sb_addr = sb_addr;  assign b0.i_sb_addr = sb_addr;
    assign b1.i_clr_req = clr_req;  assign b0.i_clr_req = clr_req;
    rf_mp_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    rf_mp_sb #(.DW(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // config index 1 = ZERO_REG/BYPASS on, 0 = both off
    function automatic logic [31:0] f_rd(input int c, input logic [4:0] a);
        if (c == 1 && a == 0) return 32'h0;
        if (c == 1 && !m_clr[c] && wr_en && wr_addr == a) return wr_data;
        return m_mem[c][a];
    endfunction
    function automatic logic [31:0] f_pd(input int c, input logic [4:0] a);
        if (c == 1 && a == 0) return 32'h0;
        if (c == 1 && !m_clr[c] && wr_en && wr_addr == a) return 32'h0;
        return {31'h0, m_pend[c][a]};
    endfunction
    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[c][i] = 0;
                m_pend[c][i] = 0;
            end
            m_clr[c] = 0;
            m_ptr[c] = 0;
        end
    endtask
    task automatic m_edge();
        for (int c = 0; c < 2; c++) begin
            if (m_clr[c]) begin
                m_mem[c][m_ptr[c]] = 0;
                if (m_ptr[c] == 5'd31) m_clr[c] = 0;
                else m_ptr[c] = m_ptr[c] + 5'd1;
            end else begin
                if (wr_en && !(c == 1 && wr_addr == 0)) begin
                    m_mem[c][wr_addr] = wr_data;
                    m_pend[c][wr_addr] = 0;
                end
                if (sb_set && !(c == 1 && sb_addr == 0)) m_pend[c][sb_addr] = 1;
                if (clr_req) begin
                    m_clr[c] = 1;
                    m_ptr[c] = (c == 1) ? 5'd1 : 5'd0;
                    for (int i = 0; i < 32; i++) m_pend[c][i] = 0;
                end
            end
        end
    endtask
    task automatic probe(input string tag);
        logic [31:0] obs [10];
        ent_t e;
        q.push_back('{{tag, ".d1"}, f_rd(1, rd_addr1)});
        q.push_back('{{tag, ".d2"}, f_rd(1, rd_addr2)});
        q.push_back('{{tag, ".p1"}, f_pd(1, rd_addr1)});
        q.push_back('{{tag, ".p2"}, f_pd(1, rd_addr2)});
        q.push_back('{{tag, ".busy"}, {31'h0, m_clr[1]}});
        q.push_back('{{tag, ".nz.d1"}, f_rd(0, rd_addr1)});
        q.push_back('{{tag, ".nz.d2"}, f_rd(0, rd_addr2)});
        q.push_back('{{tag, ".nz.p1"}, f_pd(0, rd_addr1)});
        q.push_back('{{tag, ".nz.p2"}, f_pd(0, rd_addr2)});
        q.push_back('{{tag, ".nz.busy"}, {31'h0, m_clr[0]}});
        #1;
        obs = '{b1.o_rd_data1, b1.o_rd_data2, {31'h0, b1.o_sb_pend1}, {31'h0, b1.o_sb_pend2},
                {31'h0, b1.o_clr_busy}, b0.o_rd_data1, b0.o_rd_data2, {31'h0, b0.o_sb_pend1},
                {31'h0, b0.o_sb_pend2}, {31'h0, b0.o_clr_busy}};
        for (int i = 0; i < 10; i++) begin
            e = q.pop_front();
            chk(e.tag, obs[i], e.v);
        end
    endtask
    task automatic cyc(input string tag);
        probe(tag);
        @(posedge clk);
        if (!rst) m_edge();
        #1;
    endtask
    task automatic clear_run(input string tag);
        int n;
        clr_req = 1;
        cyc({tag, ".req"});
        clr_req = 0;
        n = 0;
        while (b1.o_clr_busy && n < 100) begin
            wr_en   = (n == 3);
            wr_addr = 5'd4;
            wr_data = 32'h444;
            clr_req = (n == 10);
            rd_addr1 = 5'(n);
            rd_addr2 = 5'd4;
            cyc(tag);
            n++;
        end
        wr_en = 0;
        clr_req = 0;
        chk({tag, ".len"}, n, 31);
        cyc({tag, ".tail"});
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            cyc({tag, ".rd"});
        end
    endtask
    initial begin
        m_reset();
        rd_addr1 = 5;
        rd_addr2 = 31;
        #2;
        probe("reset");
        rst = 0;
        cyc("idle");
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; rd_addr1 = 3;
        cyc("bypass");
        wr_en = 0;
        cyc("wr3");
        wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; sb_set = 1; sb_addr = 0; rd_addr1 = 0;
        cyc("zero.w");
        wr_en = 0; sb_set = 0;
        cyc("zero.r");
        sb_set = 1; sb_addr = 7; rd_addr1 = 7;
        cyc("sb.set");
        sb_set = 0;
        cyc("sb.hold1");
        cyc("sb.hold2");
        wr_en = 1; wr_addr = 7; wr_data = 32'h77;
        cyc("sb.rel");
        wr_en = 0;
        cyc("sb.after");
        wr_en = 1; wr_addr = 9; wr_data = 32'h99; sb_set = 1; sb_addr = 9; rd_addr2 = 9;
        cyc("sb.both");
        wr_en = 0; sb_set = 0;
        cyc("sb.both.r");
        for (int i = 0; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = i;
            sb_set = 1; sb_addr = 5'(i + 5);
            rd_addr1 = 5'(i); rd_addr2 = 5'(i + 5);
            cyc("preload");
        end
        wr_en = 0; sb_set = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            cyc("loaded");
        end
        clear_run("clr1");
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'hA000 + i; sb_set = 1; sb_addr = 5'(i);
            cyc("reload");
        end
        wr_en = 0; sb_set = 0;
        clr_req = 1;
        cyc("clr2.req");
        clr_req = 0;
        repeat (10) cyc("clr2.run");
        rst = 1;
        #1;
        chk("rstmid.busy", {31'h0, b1.o_clr_busy}, 0);
        chk("rstmid.nz.busy", {31'h0, b0.o_clr_busy}, 0);
        m_reset();
        rd_addr1 = 5'd20; rd_addr2 = 5'd30;
        cyc("rstmid.hold");
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            cyc("rstmid.rd");
        end
        clear_run("clr3");
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised successor register file for the pipelined RISC-V core: 2 asynchronous read ports, 1 write port.
- Adds optional write-to-read bypass, optional hardwired-zero entry 0, and a per-entry pending-write scoreboard for ID-stage hazard detection.
- Adds a sequential bulk-clear engine that sweeps one entry per cycle.
- Sits between ID (reads, scoreboard query/set) and WB (write, scoreboard release).

Parameters:
DW, 32, data width in bits
AW, 5, address width; DEPTH = 2**AW entries (local, derived)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/scoreboard set
BYPASS, 1, 1 = read of the address being written this cycle returns wr_data

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write strobe (WB)
wr_addr  in  AW  write address
wr_data  in  DW  write data
rd_addr1  in  AW  read port 1 address
rd_data1  out  DW  read port 1 data (combinational)
rd_addr2  in  AW  read port 2 address
rd_data2  out  DW  read port 2 data (combinational)
sb_set  in  1  mark sb_addr pending (instruction issued with destination sb_addr)
sb_addr  in  AW  scoreboard set address
sb_pend1  out  1  pending bit of rd_addr1 (combinational)
sb_pend2  out  1  pending bit of rd_addr2 (combinational)
clr_req  in  1  request bulk clear of all entries
clr_busy  out  1  bulk clear in progress

Behaviour:
- Reset (async, any time incl. mid-clear): all entries = 0, all pending bits = 0, state = IDLE, clr_busy = 0, sweep pointer = 0. Read outputs then reflect zeroed array.
- State machine, 2 states:
  - IDLE: clr_req sampled 1 at posedge -> CLEAR; pointer <= FIRST (1 if ZERO_REG else 0); all pending bits <= 0 at that same edge.
  - CLEAR: each posedge writes 0 to entry[pointer] and increments pointer. When pointer == DEPTH-1, that edge clears the last entry and returns to IDLE.
  - clr_busy = (state == CLEAR), registered.
  - Duration: DEPTH-FIRST cycles; 31 for defaults.
  - clr_req while CLEAR: ignored, no restart.
- Write, IDLE only: at posedge, if wr_en and not (ZERO_REG and wr_addr == 0), entry[wr_addr] <= wr_data and pending[wr_addr] <= 0. During CLEAR, wr_en and sb_set are ignored.
- Scoreboard set, IDLE only: at posedge, if sb_set and not (ZERO_REG and sb_addr == 0), pending[sb_addr] <= 1.
  - Same edge, same address as a write: set wins, so pending stays 1 (a newer producer was issued).
  - Different addresses: both take effect.
- Read, per port:
  - If ZERO_REG and addr == 0: data 0, pend 0.
  - Else if BYPASS, state IDLE, wr_en, and wr_addr == addr: data = wr_data, pend = 0 (producer completing this cycle).
  - Else: data = entry[addr], pend = pending[addr].
  - Zero latency, no handshake.
- BYPASS = 0: reads return pre-edge array contents; write visible from the cycle after the edge.
- Widths: no arithmetic beyond pointer increment (AW bits). The pointer never wraps because the terminating compare precedes overflow.
- Synthesisable only; no $display in RTL.

Test Plan:
- Reset then read: rst pulse; rd_addr1=5, rd_addr2=31 -> rd_data1=0, rd_data2=0, sb_pend1=sb_pend2=0, clr_busy=0.
- Write/read + bypass: wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr1=3 in same cycle -> rd_data1=0xDEADBEEF before the edge (BYPASS=1). With BYPASS=0 -> 0 before the edge, 0xDEADBEEF after.
- Zero register: write 0x12345678 to addr 0 with sb_set=1, sb_addr=0 -> rd_data1=0, sb_pend1=0 at addr 0 on all later cycles. Repeat with ZERO_REG=0 -> reads 0x12345678, pend=1.
- Scoreboard: sb_set addr 7 at edge N -> sb_pend1=1 (rd_addr1=7) from N. Write addr 7 at edge N+3 -> pend=0 after N+3 and combinationally during cycle N+3. Simultaneous sb_set and wr_en on addr 9 -> pend stays 1 and data updated.
- Bulk clear:
  - Preload entries 1..31 with index values; pulse clr_req one cycle -> clr_busy high for exactly 31 cycles, all pending bits 0 immediately.
  - Write to addr 4 issued mid-clear -> ignored.
  - After clr_busy falls, all entries read 0.
- Reset mid-clear: assert rst 10 cycles into CLEAR -> clr_busy=0 immediately (async), all entries 0. A new clr_req afterwards runs a full 31-cycle sweep.
